ex_mem_pipe_stage: RTL and testbench
====================================

# ex_mem_pipe_stage

Parametrised EX→MEM pipeline stage register with valid/ready flow control, a one-entry skid buffer, flush-to-bubble and a forwarding tap. It sits between the execute stage and the memory stage. It carries the write-back/memory control bits, the ALU result, the store data and the destination register index. It allows either stage to stall without combinational ready paths crossing the stage boundary.

## Interface
- DATA_W, 32, width of ALU result and store data
- REG_AW, 5, register index width
- CTRL_W, 3, control bundle width; bit0 RegWrite, bit1 MemToReg, bit2 MemWrite; higher bits pass through
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- flush  in  1  discard all held entries (branch/exception squash)
- in_valid  in  1  EX stage presents an instruction
- in_ready  out  1  stage can accept this cycle
- in_ctrl  in  CTRL_W  control bundle
- in_alu  in  DATA_W  ALU result
- in_wdata  in  DATA_W  store data
- in_wreg  in  REG_AW  destination register
- out_valid  out  1  MEM stage sees a valid instruction
- out_ready  in  1  MEM stage consumes this cycle
- out_ctrl, out_alu, out_wdata, out_wreg  out  CTRL_W/DATA_W/DATA_W/REG_AW  head entry fields
- fwd_valid  out  1  head entry will write a nonzero register
- fwd_reg  out  REG_AW  forwarding destination (= out_wreg)
- fwd_data  out  DATA_W  forwarding value (= out_alu)
- occupancy  out  2  entries held (0..2)

## Operation
- Storage: main entry (drives outputs) + skid entry, each with a valid bit.
- States: EMPTY (neither valid), ONE (main only), FULL (main+skid). Skid is never valid without main.
- in_ready = !skid_valid && !rst. It is derived from a register only, with no combinational path from out_ready.
- acc = in_valid && in_ready; pop = out_valid && out_ready.
- EMPTY: acc → load main, go ONE.
- ONE:
  - acc && pop → load main, stay ONE.
  - acc && !pop → load skid, go FULL.
  - !acc && pop → go EMPTY.
- FULL (acc impossible):
  - pop → move skid into main, clear skid, go ONE.
  - else hold.
- flush: next state EMPTY and both valid bits cleared, regardless of acc/pop. A pop in the same cycle still counts as consumed by MEM. The incoming instruction in that cycle is dropped.
- Bubble rule: out_ctrl forced to all zeros whenever out_valid=0. A bubble must never assert RegWrite or MemWrite. Data fields hold their last value when invalid, except after rst, where they are zero.
- fwd_valid = out_valid && out_ctrl[0] && (out_wreg != 0).
- occupancy = main_valid + skid_valid.
- No arithmetic. All fields are copied bit-exact, with width set by the parameters.

## Timing
- Reset (rst high at a clk edge): all out_* = 0, out_valid = 0, fwd_valid = 0, fwd_reg = 0, fwd_data = 0, occupancy = 0. in_ready = 0 while rst is high and 1 on the first cycle after release. No output is ever X/Z.
- rst mid-operation: all held entries are discarded with the same result as flush. rst has priority over flush.
- Latency: an instruction accepted at edge N appears on out_* with out_valid=1 after edge N (visible cycle N+1).
- Throughput: 1 instruction/cycle with out_ready held high; occupancy stays ≤1.
- Stall: out_ready low for k cycles absorbs at most one extra instruction. in_ready drops the cycle after the skid fills and rises the cycle after the first pop from FULL.
- Ordering: strictly FIFO. The skid entry never overtakes main.
- Outputs hold stable while out_valid && !out_ready.

## Test plan
- Reset: drive random inputs with rst=1 for 3 cycles. Expect all outputs 0, in_ready=0, occupancy=0; release and expect in_ready=1.
- Streaming: 8 back-to-back instructions (alu=0x10..0x17, wreg=1..8, ctrl=3'b001), out_ready=1. Expect the same sequence on out_* one cycle later, fwd_valid=1, occupancy≤1.
- Stall/skid: out_ready=0 while sending A (alu 0xAAAA0000) and B (0xBBBB0000). Expect in_ready=0 after B, occupancy=2, outputs stable at A. Raise out_ready: expect A then B, in_ready back to 1.
- Flush in FULL: flush=1 with in_valid=1 (C). Expect next cycle out_valid=0, out_ctrl=0, occupancy=0, and C never appears.
- Forwarding: ctrl=3'b001 with wreg=0 → fwd_valid=0. ctrl=3'b100 (store) with wreg=7 → fwd_valid=0. ctrl=3'b011 with wreg=9 → fwd_valid=1, fwd_data=out_alu.
- Parameter sweep: DATA_W=64, REG_AW=6, CTRL_W=5. Rerun streaming with 0xFFFF_FFFF_0000_0001 and wreg=63. Expect bit-exact pass-through including ctrl[4:3].

Source files
------------

// File: rtl/ex_mem_pipe_stage_if.sv
// EX->MEM stage bus: upstream valid/ready channel, downstream head entry,
// flush control and the forwarding tap.
interface ex_mem_pipe_stage_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 3
) ();
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_wdata;
  logic [REG_AW-1:0] in_wreg;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu;
  logic [DATA_W-1:0] out_wdata;
  logic [REG_AW-1:0] out_wreg;
  logic              fwd_valid;
  logic [REG_AW-1:0] fwd_reg;
  logic [DATA_W-1:0] fwd_data;
  logic [1:0]        occupancy;

  modport master (
    output flush, in_valid, in_ctrl, in_alu, in_wdata, in_wreg, out_ready,
    input  in_ready, out_valid, out_ctrl, out_alu, out_wdata, out_wreg,
           fwd_valid, fwd_reg, fwd_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_ctrl, in_alu, in_wdata, in_wreg, out_ready,
    output in_ready, out_valid, out_ctrl, out_alu, out_wdata, out_wreg,
           fwd_valid, fwd_reg, fwd_data, occupancy
  );
endinterface

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with a one-entry skid buffer so in_ready is a pure
// register output; supports flush-to-bubble and a forwarding tap on the head.
module ex_mem_pipe_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 3
) (
  input logic                clk,
  input logic                rst,
  ex_mem_pipe_stage_if.slave bus
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wdata;
    logic [REG_AW-1:0] wreg;
  } entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;
  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  entry_t in_entry;
  logic   main_valid, skid_valid;
  logic   acc, pop;

  always_comb begin
    in_entry.ctrl  = bus.in_ctrl;
    in_entry.alu   = bus.in_alu;
    in_entry.wdata = bus.in_wdata;
    in_entry.wreg  = bus.in_wreg;
  end

  assign main_valid = (state_q != EMPTY);
  assign skid_valid = (state_q == FULL);

  assign bus.in_ready = !skid_valid && !rst;
  assign acc          = bus.in_valid && bus.in_ready;
  assign pop          = main_valid && bus.out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (acc) begin
          main_d  = in_entry;
          state_d = ONE;
        end
      end
      ONE: begin
        if (acc && pop) begin
          main_d = in_entry;
        end else if (acc) begin
          skid_d  = in_entry;
          state_d = FULL;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (pop) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush only drops validity; payload registers keep their last contents.
    if (bus.flush) begin
      state_d = EMPTY;
      main_d  = main_q;
      skid_d  = skid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  // Bubbles present all-zero control so they can never write a register or memory.
  assign bus.out_valid = main_valid;
  assign bus.out_ctrl  = main_valid ? main_q.ctrl : '0;
  assign bus.out_alu   = main_q.alu;
  assign bus.out_wdata = main_q.wdata;
  assign bus.out_wreg  = main_q.wreg;

  assign bus.fwd_valid = main_valid && main_q.ctrl[0] && (main_q.wreg != '0);
  assign bus.fwd_reg   = main_q.wreg;
  assign bus.fwd_data  = main_q.alu;
  assign bus.occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Directed self-checking bench for ex_mem_pipe_stage at default and wide parameters.
module tb_ex_mem_pipe_stage;

  logic clk = 1'b0;
  logic rst;
  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  always #5 clk = ~clk;

  ex_mem_pipe_stage_if #(.DATA_W(32), .REG_AW(5), .CTRL_W(3)) b32 ();
  ex_mem_pipe_stage_if #(.DATA_W(64), .REG_AW(6), .CTRL_W(5)) b64 ();

  ex_mem_pipe_stage #(.DATA_W(32), .REG_AW(5), .CTRL_W(3)) u_dut32 (
    .clk (clk),
    .rst (rst),
    .bus (b32)
  );

  ex_mem_pipe_stage #(.DATA_W(64), .REG_AW(6), .CTRL_W(5)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (b64)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive32(input logic v, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] w, input logic [4:0] r);
    b32.in_valid = v;
    b32.in_ctrl  = c;
    b32.in_alu   = a;
    b32.in_wdata = w;
    b32.in_wreg  = r;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [2:0] c,
                            input logic [31:0] a, input logic [4:0] r, input logic [1:0] occ);
    check({tag, ".valid"}, 64'(b32.out_valid), 64'(v));
    check({tag, ".ctrl"},  64'(b32.out_ctrl),  64'(c));
    check({tag, ".alu"},   64'(b32.out_alu),   64'(a));
    check({tag, ".wreg"},  64'(b32.out_wreg),  64'(r));
    check({tag, ".occ"},   64'(b32.occupancy), 64'(occ));
  endtask

  initial begin
    logic [63:0] alu64 [4];
    logic [4:0]  ctl64 [4];
    logic [5:0]  reg64 [4];
    logic        fwd64 [4];

    alu64 = '{64'hFFFF_FFFF_0000_0001, 64'h8000_0000_0000_0000,
              64'h0123_4567_89AB_CDEF, 64'hFFFF_FFFF_FFFF_FFFF};
    ctl64 = '{5'b11001, 5'b10001, 5'b01001, 5'b11101};
    reg64 = '{6'd63, 6'd62, 6'd1, 6'd0};
    fwd64 = '{1'b1, 1'b1, 1'b1, 1'b0};

    // Reset with random inputs on both instances
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      b32.flush = 1'($urandom); b32.out_ready = 1'($urandom);
      drive32(1'($urandom), 3'($urandom), $urandom, $urandom, 5'($urandom));
      b64.flush = 1'($urandom); b64.out_ready = 1'($urandom);
      b64.in_valid = 1'($urandom); b64.in_ctrl = 5'($urandom);
      b64.in_alu = {$urandom, $urandom}; b64.in_wdata = {$urandom, $urandom};
      b64.in_wreg = 6'($urandom);
      step();
      check_head("rst", 1'b0, 3'd0, 32'd0, 5'd0, 2'd0);
      check("rst.in_ready",  64'(b32.in_ready),  64'd0);
      check("rst.fwd_valid", 64'(b32.fwd_valid), 64'd0);
      check("rst.fwd_data",  64'(b32.fwd_data),  64'd0);
      check("rst.wdata",     64'(b32.out_wdata), 64'd0);
      check("rst64.alu",     b64.out_alu,        64'd0);
      check("rst64.occ",     64'(b64.occupancy), 64'd0);
    end
    rst = 1'b0;
    b32.flush = 1'b0; b32.out_ready = 1'b1;
    drive32(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    b64.flush = 1'b0; b64.out_ready = 1'b1; b64.in_valid = 1'b0;
    step();
    check("rel.in_ready", 64'(b32.in_ready), 64'd1);
    check_head("rel", 1'b0, 3'd0, 32'd0, 5'd0, 2'd0);

    // Streaming, one per cycle
    for (int i = 0; i < 8; i++) begin
      drive32(1'b1, 3'b001, 32'h10 + 32'(i), 32'h100 + 32'(i), 5'(i + 1));
      step();
      check_head("stream", 1'b1, 3'b001, 32'h10 + 32'(i), 5'(i + 1), 2'd1);
      check("stream.wdata", 64'(b32.out_wdata), 64'h100 + 64'(i));
      check("stream.fwd",   64'(b32.fwd_valid), 64'd1);
      check("stream.rdy",   64'(b32.in_ready),  64'd1);
    end
    drive32(1'b0, 3'b001, 32'h0, 32'h0, 5'd0);
    step();
    check_head("stream.idle", 1'b0, 3'd0, 32'h17, 5'd8, 2'd0);
    check("stream.idle.fwd", 64'(b32.fwd_valid), 64'd0);

    // Stall: A then B into the skid, D must be refused
    b32.out_ready = 1'b0;
    drive32(1'b1, 3'b001, 32'hAAAA_0000, 32'h1, 5'd2);
    step();
    check_head("stallA", 1'b1, 3'b001, 32'hAAAA_0000, 5'd2, 2'd1);
    check("stallA.rdy", 64'(b32.in_ready), 64'd1);
    drive32(1'b1, 3'b011, 32'hBBBB_0000, 32'h2, 5'd3);
    step();
    check_head("stallB", 1'b1, 3'b001, 32'hAAAA_0000, 5'd2, 2'd2);
    check("stallB.rdy", 64'(b32.in_ready), 64'd0);
    drive32(1'b1, 3'b001, 32'hDDDD_0000, 32'h3, 5'd4);
    step();
    check_head("stallHold", 1'b1, 3'b001, 32'hAAAA_0000, 5'd2, 2'd2);
    check("stallHold.wdata", 64'(b32.out_wdata), 64'h1);
    drive32(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    b32.out_ready = 1'b1;
    step();
    check_head("drainB", 1'b1, 3'b011, 32'hBBBB_0000, 5'd3, 2'd1);
    check("drainB.rdy", 64'(b32.in_ready), 64'd1);
    step();
    check_head("drainEnd", 1'b0, 3'd0, 32'hBBBB_0000, 5'd3, 2'd0);

    // Flush while FULL, with C offered
    b32.out_ready = 1'b0;
    drive32(1'b1, 3'b101, 32'hEEEE_0000, 32'h4, 5'd5);
    step();
    drive32(1'b1, 3'b101, 32'hFFFF_0000, 32'h5, 5'd6);
    step();
    check("flushF.pre", 64'(b32.occupancy), 64'd2);
    b32.flush = 1'b1;
    drive32(1'b1, 3'b111, 32'hCCCC_0000, 32'h6, 5'd7);
    step();
    check_head("flushF", 1'b0, 3'd0, 32'hEEEE_0000, 5'd5, 2'd0);
    check("flushF.rdy", 64'(b32.in_ready), 64'd1);
    b32.flush = 1'b0; b32.out_ready = 1'b1;
    drive32(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    check_head("flushF.after", 1'b0, 3'd0, 32'hEEEE_0000, 5'd5, 2'd0);

    // Flush in ONE while an instruction is accepted: it must be dropped
    drive32(1'b1, 3'b001, 32'h6666_0000, 32'h7, 5'd8);
    b32.out_ready = 1'b0;
    step();
    check("flushO.pre", 64'(b32.occupancy), 64'd1);
    b32.flush = 1'b1;
    drive32(1'b1, 3'b001, 32'h7777_0000, 32'h8, 5'd9);
    step();
    check_head("flushO", 1'b0, 3'd0, 32'h6666_0000, 5'd8, 2'd0);
    b32.flush = 1'b0; b32.out_ready = 1'b1;
    drive32(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    check_head("flushO.after", 1'b0, 3'd0, 32'h6666_0000, 5'd8, 2'd0);

    // Forwarding qualification
    drive32(1'b1, 3'b001, 32'h1111_0000, 32'h0, 5'd0);
    step();
    check("fwd.r0.valid", 64'(b32.out_valid), 64'd1);
    check("fwd.r0",       64'(b32.fwd_valid), 64'd0);
    drive32(1'b1, 3'b100, 32'h2222_0000, 32'h9, 5'd7);
    step();
    check("fwd.st",       64'(b32.fwd_valid), 64'd0);
    check("fwd.st.ctrl",  64'(b32.out_ctrl),  64'b100);
    drive32(1'b1, 3'b011, 32'h1234_5678, 32'hA, 5'd9);
    step();
    check("fwd.ld",       64'(b32.fwd_valid), 64'd1);
    check("fwd.ld.data",  64'(b32.fwd_data),  64'h1234_5678);
    check("fwd.ld.reg",   64'(b32.fwd_reg),   64'd9);

    // Reset mid-operation while FULL, with flush also asserted
    b32.out_ready = 1'b0;
    drive32(1'b1, 3'b001, 32'h3333_0000, 32'hB, 5'd10);
    step();
    check("midrst.pre", 64'(b32.occupancy), 64'd2);
    rst = 1'b1; b32.flush = 1'b1;
    #1;
    check("midrst.rdy", 64'(b32.in_ready), 64'd0);
    step();
    check_head("midrst", 1'b0, 3'd0, 32'd0, 5'd0, 2'd0);
    check("midrst.fwd_reg", 64'(b32.fwd_reg), 64'd0);
    rst = 1'b0; b32.flush = 1'b0; b32.out_ready = 1'b1;
    drive32(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    step();
    check("midrst.rel", 64'(b32.in_ready), 64'd1);

    // Wide instance streaming, bit-exact pass-through including upper ctrl bits
    for (int i = 0; i < 4; i++) begin
      b64.in_valid = 1'b1;
      b64.in_ctrl  = ctl64[i];
      b64.in_alu   = alu64[i];
      b64.in_wdata = ~alu64[i];
      b64.in_wreg  = reg64[i];
      step();
      check("w64.valid", 64'(b64.out_valid), 64'd1);
      check("w64.ctrl",  64'(b64.out_ctrl),  64'(ctl64[i]));
      check("w64.alu",   b64.out_alu,        alu64[i]);
      check("w64.wdata", b64.out_wdata,      ~alu64[i]);
      check("w64.wreg",  64'(b64.out_wreg),  64'(reg64[i]));
      check("w64.fwd",   64'(b64.fwd_valid), 64'(fwd64[i]));
      check("w64.occ",   64'(b64.occupancy), 64'd1);
    end
    b64.in_valid = 1'b0;
    step();
    check("w64.idle.ctrl", 64'(b64.out_ctrl), 64'd0);
    check("w64.idle.occ",  64'(b64.occupancy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
